// File: rtl/cpu_sequencer_pkg.sv
// Shared constants for the 4-bit CPU sequencer: widths, opcodes,
// datapath source selects and the fetch/execute state encoding.
package cpu_sequencer_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DAT_W_DEF  = 4;
  localparam int OP_W_DEF   = 4;

  // Opcodes (upper nibble of the instruction byte)
  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  // Datapath source selects
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bus between the sequencer and its ROM / register-file / ALU neighbours.
interface cpu_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DAT_W  = 4,
  parameter int OP_W   = 4
);
  logic [ADDR_W-1:0]      rom_addr;
  logic [OP_W+DAT_W-1:0]  rom_dat;
  logic                   alu_carry;
  logic [1:0]             sel;
  logic [DAT_W-1:0]       imm;
  logic                   load_a;
  logic                   load_b;
  logic                   load_out;
  logic                   carry;
  logic                   exec;

  modport master (
    output rom_addr, sel, imm, load_a, load_b, load_out, carry, exec,
    input  rom_dat, alu_carry
  );

  modport slave (
    input  rom_addr, sel, imm, load_a, load_b, load_out, carry, exec,
    output rom_dat, alu_carry
  );
endinterface

// File: rtl/cpu_sequencer_decode.sv
// Combinational instruction decoder: turns the registered opcode and
// phase into source select, load strobes and PC/carry control.
module cpu_decode
  import cpu_sequencer_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] opcode,
  input  logic            exec,
  input  logic            carry,
  output logic [1:0]      sel,
  output logic            load_a,
  output logic            load_b,
  output logic            load_out,
  output logic            imm_zero,
  output logic            jump_taken,
  output logic            is_add
);

  // Opcode table; outside EXEC everything idles with the zero source selected
  always_comb begin
    sel        = SEL_ZERO;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_out   = 1'b0;
    imm_zero   = 1'b0;
    jump_taken = 1'b0;
    is_add     = 1'b0;
    if (exec) begin
      case (opcode)
        OP_ADD_A:  begin sel = SEL_A;    load_a   = 1'b1; is_add   = 1'b1; end
        OP_ADD_B:  begin sel = SEL_B;    load_b   = 1'b1; is_add   = 1'b1; end
        OP_MOV_A:  begin sel = SEL_ZERO; load_a   = 1'b1; end
        OP_MOV_B:  begin sel = SEL_ZERO; load_b   = 1'b1; end
        OP_MOV_AB: begin sel = SEL_B;    load_a   = 1'b1; imm_zero = 1'b1; end
        OP_MOV_BA: begin sel = SEL_A;    load_b   = 1'b1; imm_zero = 1'b1; end
        OP_IN_A:   begin sel = SEL_IN;   load_a   = 1'b1; imm_zero = 1'b1; end
        OP_IN_B:   begin sel = SEL_IN;   load_b   = 1'b1; imm_zero = 1'b1; end
        OP_OUT_B:  begin sel = SEL_B;    load_out = 1'b1; imm_zero = 1'b1; end
        OP_OUT_IM: begin sel = SEL_ZERO; load_out = 1'b1; end
        OP_JMP:    begin jump_taken = 1'b1; end
        // JNC looks at the carry held from the previous instruction
        OP_JNC:    begin jump_taken = ~carry; end
        default:   begin sel = SEL_ZERO; end
      endcase
    end else begin
      sel = SEL_ZERO;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer for the 4-bit CPU: owns PC, IR and carry,
// and drives the register-file write strobes from the registered IR.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DAT_W  = DAT_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic             clk_cpu,
  input  logic             reset,
  cpu_sequencer_if.master  bus
);

  state_t                 state;
  logic [ADDR_W-1:0]      pc;
  logic [OP_W+DAT_W-1:0]  ir;
  logic                   carry_q;

  logic [OP_W-1:0]        opcode;
  logic [DAT_W-1:0]       imm_field;
  logic                   exec_state;
  logic [1:0]             dec_sel;
  logic                   dec_load_a;
  logic                   dec_load_b;
  logic                   dec_load_out;
  logic                   dec_imm_zero;
  logic                   dec_jump;
  logic                   dec_is_add;

  assign opcode     = ir[DAT_W+OP_W-1:DAT_W];
  assign imm_field  = ir[DAT_W-1:0];
  assign exec_state = (state == ST_EXEC);

  cpu_decode #(.OP_W(OP_W)) u_decode (
    .opcode     (opcode),
    .exec       (exec_state),
    .carry      (carry_q),
    .sel        (dec_sel),
    .load_a     (dec_load_a),
    .load_b     (dec_load_b),
    .load_out   (dec_load_out),
    .imm_zero   (dec_imm_zero),
    .jump_taken (dec_jump),
    .is_add     (dec_is_add)
  );

  // Two-phase FSM: FETCH latches the instruction, EXEC retires it (PC, carry)
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state   <= ST_FETCH;
      pc      <= '0;
      ir      <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          ir    <= bus.rom_dat;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (dec_jump) begin
            pc <= ADDR_W'(imm_field);
          end else begin
            pc <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
          carry_q <= dec_is_add ? bus.alu_carry : 1'b0;
          state   <= ST_FETCH;
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

  // Outputs come straight from registers through the decoder; reset kills
  // strobes and exec in the same cycle so no register write can slip through.
  assign bus.rom_addr = pc;
  assign bus.sel      = dec_sel;
  assign bus.imm      = dec_imm_zero ? '0 : imm_field;
  assign bus.load_a   = dec_load_a   & ~reset;
  assign bus.load_b   = dec_load_b   & ~reset;
  assign bus.load_out = dec_load_out & ~reset;
  assign bus.exec     = exec_state   & ~reset;
  assign bus.carry    = carry_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus a
// randomized run against an instruction-level reference model.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_c;
  logic [7:0] rom [16];
  int         vectors = 0;
  int         errors  = 0;

  // Reference model state (instruction-level view)
  int         m_pc;
  bit         m_carry;
  bit         m_exec;
  logic [7:0] m_ir;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.ADDR_W(4), .DAT_W(4), .OP_W(4)) bus ();

  assign bus.rom_dat   = rom[bus.rom_addr];
  assign bus.alu_carry = alu_c;

  cpu_sequencer dut (
    .clk_cpu (clk),
    .reset   (reset),
    .bus     (bus)
  );

  // Instruction table: source, destination strobe, immediate zeroing, ADD flag
  function automatic void ref_op(input logic [3:0] op, output logic [1:0] s,
                                 output logic la, output logic lb, output logic lo,
                                 output logic iz, output logic add);
    s = 2'd3; la = 1'b0; lb = 1'b0; lo = 1'b0; iz = 1'b0; add = 1'b0;
    case (op)
      4'h0: begin s = 2'd0; la = 1'b1; add = 1'b1; end
      4'h5: begin s = 2'd1; lb = 1'b1; add = 1'b1; end
      4'h3: begin s = 2'd3; la = 1'b1; end
      4'h7: begin s = 2'd3; lb = 1'b1; end
      4'h1: begin s = 2'd1; la = 1'b1; iz = 1'b1; end
      4'h4: begin s = 2'd0; lb = 1'b1; iz = 1'b1; end
      4'h2: begin s = 2'd2; la = 1'b1; iz = 1'b1; end
      4'h6: begin s = 2'd2; lb = 1'b1; iz = 1'b1; end
      4'h9: begin s = 2'd1; lo = 1'b1; iz = 1'b1; end
      4'hB: begin s = 2'd3; lo = 1'b1; end
      default: begin s = 2'd3; end
    endcase
  endfunction

  // One clock: model retires/fetches exactly as the DUT should, then settle to negedge
  task automatic tick();
    logic [1:0] s;
    logic la, lb, lo, iz, add;
    logic [3:0] op;
    @(posedge clk);
    if (reset) begin
      m_pc = 0; m_carry = 1'b0; m_exec = 1'b0; m_ir = 8'h00;
    end else if (!m_exec) begin
      m_ir = rom[m_pc];
      m_exec = 1'b1;
    end else begin
      op = m_ir[7:4];
      ref_op(op, s, la, lb, lo, iz, add);
      if (op == 4'hF || (op == 4'hE && !m_carry)) m_pc = int'(m_ir[3:0]);
      else m_pc = (m_pc + 1) % 16;
      m_carry = add ? alu_c : 1'b0;
      m_exec = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; alu_c = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  task automatic test_reset();
    fill_rom(8'h80);
    rom[0] = 8'h0F; rom[1] = 8'h35;
    do_reset();
    tick(); alu_c = 1'b1;           // EXEC of ADD A,F with carry out
    tick(); alu_c = 1'b0;           // FETCH pc=1, carry=1
    vectors++; if (bus.carry !== 1'b1) begin errors++; $display("FAIL rst_pre_carry got %b want 1", bus.carry); end
    tick();                         // EXEC MOV A,5
    vectors++; if (bus.load_a !== 1'b1) begin errors++; $display("FAIL rst_pre_load got %b want 1", bus.load_a); end
    reset = 1'b1; #1;
    vectors++; if ({bus.load_a, bus.load_b, bus.load_out, bus.exec} !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_exec strobes/exec got %b want 0000", {bus.load_a, bus.load_b, bus.load_out, bus.exec}); end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if ({bus.load_a, bus.load_b, bus.load_out, bus.exec} !== 4'b0000) begin
        errors++; $display("FAIL rst_hold[%0d] strobes/exec got %b want 0000", i, {bus.load_a, bus.load_b, bus.load_out, bus.exec}); end
      vectors++; if (bus.rom_addr !== 4'd0 || bus.carry !== 1'b0) begin
        errors++; $display("FAIL rst_hold[%0d] pc/carry got %0d/%b want 0/0", i, bus.rom_addr, bus.carry); end
    end
    reset = 1'b0; #1;
    vectors++; if (bus.rom_addr !== 4'd0 || bus.exec !== 1'b0) begin
      errors++; $display("FAIL rst_first_fetch addr/exec got %0d/%b want 0/0", bus.rom_addr, bus.exec); end
    tick();
    vectors++; if (bus.load_a !== 1'b1 || bus.sel !== 2'b00 || bus.imm !== 4'hF) begin
      errors++; $display("FAIL rst_first_exec la/sel/imm got %b/%b/%h want 1/00/f", bus.load_a, bus.sel, bus.imm); end
  endtask

  task automatic test_sequence();
    logic [3:0] exp_addr [5];
    fill_rom(8'h80);
    rom[0] = 8'h35; rom[1] = 8'h72;
    exp_addr[0] = 4'd0; exp_addr[1] = 4'd0; exp_addr[2] = 4'd1; exp_addr[3] = 4'd1; exp_addr[4] = 4'd2;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      vectors++; if (bus.rom_addr !== exp_addr[c]) begin
        errors++; $display("FAIL seq_addr[%0d] got %0d want %0d", c, bus.rom_addr, exp_addr[c]); end
      if (c == 1) begin
        vectors++; if (bus.load_a !== 1'b1 || bus.load_b !== 1'b0 || bus.sel !== 2'b11 || bus.imm !== 4'd5) begin
          errors++; $display("FAIL seq_mov_a la/lb/sel/imm got %b/%b/%b/%h want 1/0/11/5", bus.load_a, bus.load_b, bus.sel, bus.imm); end
      end
      if (c == 3) begin
        vectors++; if (bus.load_b !== 1'b1 || bus.load_a !== 1'b0 || bus.sel !== 2'b11 || bus.imm !== 4'd2) begin
          errors++; $display("FAIL seq_mov_b lb/la/sel/imm got %b/%b/%b/%h want 1/0/11/2", bus.load_b, bus.load_a, bus.sel, bus.imm); end
      end
      if (c == 2) begin
        vectors++; if (bus.exec !== 1'b0 || bus.sel !== 2'b11 || bus.imm !== 4'd5) begin
          errors++; $display("FAIL seq_fetch exec/sel/imm got %b/%b/%h want 0/11/5", bus.exec, bus.sel, bus.imm); end
      end
      tick();
    end
  endtask

  task automatic test_add_carry();
    fill_rom(8'h80);
    rom[0] = 8'h0F; rom[1] = 8'h30;
    do_reset();
    tick(); alu_c = 1'b1;
    vectors++; if (bus.load_a !== 1'b1 || bus.sel !== 2'b00 || bus.imm !== 4'hF) begin
      errors++; $display("FAIL add_exec la/sel/imm got %b/%b/%h want 1/00/f", bus.load_a, bus.sel, bus.imm); end
    tick(); alu_c = 1'b0;
    vectors++; if (bus.carry !== 1'b1) begin errors++; $display("FAIL add_carry_set got %b want 1", bus.carry); end
    tick(); alu_c = 1'b1;           // MOV A,0 must clear carry whatever the adder says
    tick(); alu_c = 1'b0;
    vectors++; if (bus.carry !== 1'b0) begin errors++; $display("FAIL add_carry_clear got %b want 0", bus.carry); end
  endtask

  task automatic test_jumps();
    fill_rom(8'h80);
    rom[0] = 8'h0F; rom[1] = 8'hE7; rom[2] = 8'hE7; rom[7] = 8'hF3;
    rom[3] = 8'h0F; rom[4] = 8'hFA;
    do_reset();
    tick(); alu_c = 1'b1; tick(); alu_c = 1'b0;   // ADD -> carry=1, pc=1
    tick(); tick();                               // JNC with carry=1: not taken
    vectors++; if (bus.rom_addr !== 4'd2) begin errors++; $display("FAIL jnc_not_taken pc got %0d want 2", bus.rom_addr); end
    tick(); tick();                               // JNC with carry=0: taken
    vectors++; if (bus.rom_addr !== 4'd7) begin errors++; $display("FAIL jnc_taken pc got %0d want 7", bus.rom_addr); end
    tick(); tick();                               // JMP 3
    vectors++; if (bus.rom_addr !== 4'd3) begin errors++; $display("FAIL jmp pc got %0d want 3", bus.rom_addr); end
    tick(); alu_c = 1'b1; tick(); alu_c = 1'b0;   // ADD -> carry=1
    tick(); tick();                               // JMP A with carry set
    vectors++; if (bus.rom_addr !== 4'hA || bus.carry !== 1'b0) begin
      errors++; $display("FAIL jmp_with_carry pc/carry got %0d/%b want 10/0", bus.rom_addr, bus.carry); end
  endtask

  task automatic test_wrap();
    fill_rom(8'h80);
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      vectors++; if (bus.rom_addr !== 4'(i % 16)) begin
        errors++; $display("FAIL wrap_addr[%0d] got %0d want %0d", i, bus.rom_addr, i % 16); end
      tick();
      vectors++; if ({bus.load_a, bus.load_b, bus.load_out} !== 3'b000) begin
        errors++; $display("FAIL wrap_strobe[%0d] got %b want 000", i, {bus.load_a, bus.load_b, bus.load_out}); end
      tick();
    end
    rom[0] = 8'hFE; rom[14] = 8'h0F; rom[15] = 8'hE5;
    do_reset();
    tick(); tick();                               // JMP 14
    tick(); alu_c = 1'b1; tick(); alu_c = 1'b0;   // ADD at 14 -> carry=1
    vectors++; if (bus.rom_addr !== 4'd15 || bus.carry !== 1'b1) begin
      errors++; $display("FAIL wrap_add pc/carry got %0d/%b want 15/1", bus.rom_addr, bus.carry); end
    tick(); tick();                               // JNC at 15 not taken -> wrap
    vectors++; if (bus.rom_addr !== 4'd0 || bus.carry !== 1'b0) begin
      errors++; $display("FAIL wrap_jnc pc/carry got %0d/%b want 0/0", bus.rom_addr, bus.carry); end
  endtask

  task automatic test_moves();
    logic [7:0] prog [4];
    logic [5:0] want [4];   // {la, lb, lo, sel, imm_is_nine}
    prog[0] = 8'h10; prog[1] = 8'h40; prog[2] = 8'h90; prog[3] = 8'hB9;
    want[0] = {1'b1, 1'b0, 1'b0, 2'b01, 1'b0};
    want[1] = {1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
    want[2] = {1'b0, 1'b0, 1'b1, 2'b01, 1'b0};
    want[3] = {1'b0, 1'b0, 1'b1, 2'b11, 1'b1};
    fill_rom(8'h80);
    for (int i = 0; i < 4; i++) rom[i] = prog[i];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if ({bus.load_a, bus.load_b, bus.load_out, bus.sel} !== want[i][5:1]) begin
        errors++; $display("FAIL move[%0d] la/lb/lo/sel got %b want %b", i, {bus.load_a, bus.load_b, bus.load_out, bus.sel}, want[i][5:1]); end
      vectors++; if (bus.imm !== (want[i][0] ? 4'd9 : 4'd0)) begin
        errors++; $display("FAIL move_imm[%0d] got %h want %h", i, bus.imm, want[i][0] ? 4'd9 : 4'd0); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [1:0] s;
    logic la, lb, lo, iz, add, ex;
    logic [3:0] imm_e;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) for (int k = 0; k < 16; k++) rom[k] = 8'($urandom);
      reset = ($urandom_range(0, 39) == 0);
      alu_c = 1'($urandom_range(0, 1));
      #1;
      if (m_exec) ref_op(m_ir[7:4], s, la, lb, lo, iz, add);
      else begin s = 2'd3; la = 1'b0; lb = 1'b0; lo = 1'b0; iz = 1'b0; add = 1'b0; end
      ex = m_exec && !reset;
      la = la && !reset; lb = lb && !reset; lo = lo && !reset;
      imm_e = iz ? 4'd0 : m_ir[3:0];
      vectors++; if (bus.rom_addr !== 4'(m_pc)) begin
        errors++; $display("FAIL rnd_addr[%0d] got %0d want %0d", i, bus.rom_addr, m_pc); end
      vectors++; if ({bus.exec, bus.load_a, bus.load_b, bus.load_out} !== {ex, la, lb, lo}) begin
        errors++; $display("FAIL rnd_strobes[%0d] ex/la/lb/lo got %b want %b ir=%h", i, {bus.exec, bus.load_a, bus.load_b, bus.load_out}, {ex, la, lb, lo}, m_ir); end
      vectors++; if (bus.carry !== m_carry) begin
        errors++; $display("FAIL rnd_carry[%0d] got %b want %b", i, bus.carry, m_carry); end
      if (!reset) begin
        vectors++; if (bus.imm !== imm_e) begin
          errors++; $display("FAIL rnd_imm[%0d] got %h want %h ir=%h", i, bus.imm, imm_e, m_ir); end
        if (la || lb || lo || !m_exec) begin
          vectors++; if (bus.sel !== s) begin
            errors++; $display("FAIL rnd_sel[%0d] got %b want %b ir=%h", i, bus.sel, s, m_ir); end
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; alu_c = 1'b0;
    m_pc = 0; m_carry = 1'b0; m_exec = 1'b0; m_ir = 8'h00;
    fill_rom(8'h80);
    @(negedge clk);
    test_reset();
    test_sequence();
    test_add_carry();
    test_jumps();
    test_wrap();
    test_moves();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Fetch/execute control unit for the 4-bit CPU. It is the write-side driver of the register files.
- Holds the PC, instruction register (IR) and carry flag.
- Fetches 8-bit instructions from ROM and decodes them into one-cycle load strobes, the data-source select and the immediate for the A, B and OUT registers.
- Sits between the program ROM and the register_file/ALU datapath.

Parameters:
ADDR_W, 4, PC/ROM address width; PC wraps modulo 2^ADDR_W
DAT_W, 4, datapath width; immediate = rom_dat[DAT_W-1:0]
OP_W, 4, opcode width; opcode = rom_dat[DAT_W+OP_W-1:DAT_W]

Ports:
clk_cpu  in  1  CPU clock, all state on rising edge
reset  in  1  synchronous, active-high reset
rom_addr  out  ADDR_W  ROM address, equals PC
rom_dat  in  OP_W+DAT_W  instruction from ROM (combinational ROM)
alu_carry  in  1  adder carry-out for current EXEC operands
sel  out  2  datapath source: 00=A, 01=B, 10=IN port, 11=zero
imm  out  DAT_W  immediate field of IR
load_a  out  1  write strobe, register A
load_b  out  1  write strobe, register B
load_out  out  1  write strobe, output register
carry  out  1  carry flag
exec  out  1  high during EXEC phase

Behaviour:
- Interface: one clock, clk_cpu. Reset is synchronous and active-high on port reset.
- Reset (sampled at posedge): state=FETCH, pc=0, ir=0, carry=0.
  - While reset=1: load_a, load_b, load_out, exec forced 0 that same cycle, even mid-EXEC.
- FSM, two states, every instruction takes exactly 2 cycles:
  - FETCH: rom_addr=pc. At posedge, ir<=rom_dat, state<=EXEC. No load strobes.
  - EXEC: exec=1. Exactly one or zero load strobes high for the whole cycle, decoded only from registered ir and state (glitch-free at the sampling edge).
  - At end of EXEC: pc and carry update, state<=FETCH.
- Opcodes (sel / strobe / imm usage):
  - 0000 ADD A,Im: sel=A, load_a
  - 0101 ADD B,Im: sel=B, load_b
  - 0011 MOV A,Im: sel=zero, load_a
  - 0111 MOV B,Im: sel=zero, load_b
  - 0001 MOV A,B: sel=B, load_a, imm forced 0
  - 0100 MOV B,A: sel=A, load_b, imm forced 0
  - 0010 IN A: sel=IN, load_a, imm 0
  - 0110 IN B: sel=IN, load_b, imm 0
  - 1001 OUT B: sel=B, load_out, imm 0
  - 1011 OUT Im: sel=zero, load_out
  - 1111 JMP Im: no load
  - 1110 JNC Im: no load
  - All other opcodes: NOP, no load
- ALU datapath is external (result = source + imm). This block only selects.
- PC: at end of EXEC, pc <= imm if (JMP) or (JNC and carry==0), else pc+1.
  - Wrap: 15 -> 0.
  - JNC tests the carry value held before the update.
- Carry: at end of EXEC, carry <= alu_carry for both ADDs; carry <= 0 for every other opcode, including NOP and jumps.
- Outside EXEC: sel=zero (11), imm=ir immediate, all strobes 0.
- A carry generated by the final ADD before a wrap is kept. A JNC at pc=15 that is not taken wraps pc to 0.

Decomposition:
- Opcode constants (OP_ADD_A … OP_JNC), sel codes (SEL_A, SEL_B, SEL_IN, SEL_ZERO) and FSM state encodings go in the shared defines.v include, alongside HCYCL/HSTRB.
- One natural sub-module: cpu_decode.
  - Purely combinational: ir, exec, carry -> sel, strobes, imm_zero, jump_taken, is_add.
  - cpu_sequencer keeps the FSM, pc, ir and carry registers.

Test Plan:
- Reset: hold reset 5 cycles mid-program -> pc=0, carry=0, exec=0, all strobes 0 every cycle while reset=1; first FETCH rom_addr=0.
- Sequence: ROM[0]=0x35 (MOV A,5), ROM[1]=0x72 (MOV B,2) -> cycle 2: load_a=1, sel=11, imm=5; cycle 4: load_b=1, imm=2; rom_addr 0,0,1,1,2.
- ADD carry: ROM[0]=0x0F with alu_carry=1 in EXEC -> load_a=1, sel=00, imm=F, carry=1 after; next instr MOV A,0 -> carry=0.
- JNC: carry=1 then 0xE7 -> pc becomes old+1. With carry=0, 0xE7 -> pc=7. JMP 0xF3 -> pc=3 regardless of carry.
- Wrap: run 16 NOPs (0x80) from pc=0 -> rom_addr 0..15 then 0; never any strobe.
- Moves/out: 0x10, 0x40, 0x90, 0xB9 -> load_a sel=01 imm=0; load_b sel=00; load_out sel=01; load_out sel=11 imm=9.
